// File: rtl/result_store_ctrl.sv
// Sequencer between the convolution output datapath and the result register file.
// Assigns raster-order (i, j) indices to accepted results and pulses done at frame end.
module result_store_ctrl #(
   parameter int unsigned W  = 28,
   parameter int unsigned H  = 28,
   parameter int unsigned DW = 19
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_start,
   input  logic          i_abort,
   input  logic          i_hold,
   input  logic          i_in_valid,
   input  logic [DW-1:0] i_in_data,
   output logic          o_in_ready,
   output logic          o_store,
   output logic [DW-1:0] o_result,
   output logic [4:0]    o_i,
   output logic [4:0]    o_j,
   output logic          o_done,
   output logic          o_busy
);

   typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_t;

   localparam logic [4:0] LastCol = 5'(W - 1);
   localparam logic [4:0] LastRow = 5'(H - 1);

   state_t          r_state, w_state_d;
   logic [4:0]      r_row, r_col, w_row_d, w_col_d;
   logic            r_store;
   logic [DW-1:0]   r_result;
   logic [4:0]      r_i, r_j;
   logic            w_accept;
   logic            w_last;

   // in_ready depends only on state and hold so the source cannot form a loop through it
   assign o_in_ready = (r_state == StRun) && !i_hold;
   assign w_accept   = i_in_valid && o_in_ready;
   assign w_last     = (r_row == LastRow) && (r_col == LastCol);

   always_comb begin
      w_state_d = r_state;
      w_row_d   = r_row;
      w_col_d   = r_col;
      if (i_abort) begin
         w_state_d = StIdle;
         w_row_d   = 5'd0;
         w_col_d   = 5'd0;
      end else begin
         case (r_state)
            StIdle: begin
               if (i_start) begin
                  w_state_d = StRun;
                  w_row_d   = 5'd0;
                  w_col_d   = 5'd0;
               end
            end
            StRun: begin
               if (w_accept) begin
                  if (r_col == LastCol) begin
                     w_col_d = 5'd0;
                     w_row_d = r_row + 5'd1;
                  end else begin
                     w_col_d = r_col + 5'd1;
                  end
                  if (w_last) begin
                     w_state_d = StFlush;
                  end
               end
            end
            StFlush: w_state_d = StDone;
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= StIdle;
         r_row   <= 5'd0;
         r_col   <= 5'd0;
      end else begin
         r_state <= w_state_d;
         r_row   <= w_row_d;
         r_col   <= w_col_d;
      end
   end

   // An accept on the abort cycle still produces its store on the following cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_store  <= 1'b0;
         r_result <= '0;
         r_i      <= 5'd0;
         r_j      <= 5'd0;
      end else begin
         r_store <= w_accept;
         if (w_accept) begin
            r_result <= i_in_data;
            r_i      <= r_row;
            r_j      <= r_col;
         end
      end
   end

   assign o_store  = r_store;
   assign o_result = r_result;
   assign o_i      = r_i;
   assign o_j      = r_j;
   assign o_done   = (r_state == StDone);
   assign o_busy   = (r_state == StRun) || (r_state == StFlush);

endmodule

// File: tb/tb_result_store_ctrl.sv
// Bench for result_store_ctrl: vector table, directed frame sequences and random traffic
// checked against a count-based model of the raster sequencer.
module tb_result_store_ctrl;

   localparam int W  = 28;
   localparam int H  = 28;
   localparam int DW = 19;
   localparam int N  = W * H;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0, abort = 1'b0, hold = 1'b0, valid = 1'b0;
   logic [DW-1:0] data = '0;
   logic          in_ready, store, done, busy;
   logic [DW-1:0] result;
   logic [4:0]    oi, oj;

   // Second instance for the single-element frame
   logic          s_start = 1'b0, s_valid = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic          s_ready, s_store, s_done, s_busy;
   logic [DW-1:0] s_result;
   logic [4:0]    s_i, s_j;

   int n_cmp = 0;
   int n_err = 0;
   int tb_stores = 0;
   int tb_dones = 0;

   // Model: phase 0 idle, 1 run, 2 flush, 3 done; m_n counts accepts in the frame
   int            m_phase = 0;
   int            m_n = 0;
   logic          m_store = 1'b0;
   logic [DW-1:0] m_res = '0;
   int            m_i = 0, m_j = 0;

   always #5 clk = ~clk;

   result_store_ctrl #(.W(W), .H(H), .DW(DW)) u_dut (
      .clk(clk), .rst(rst), .i_start(start), .i_abort(abort), .i_hold(hold),
      .i_in_valid(valid), .i_in_data(data), .o_in_ready(in_ready), .o_store(store),
      .o_result(result), .o_i(oi), .o_j(oj), .o_done(done), .o_busy(busy)
   );

   result_store_ctrl #(.W(1), .H(1), .DW(DW)) u_dut1 (
      .clk(clk), .rst(rst), .i_start(s_start), .i_abort(1'b0), .i_hold(1'b0),
      .i_in_valid(s_valid), .i_in_data(s_data), .o_in_ready(s_ready), .o_store(s_store),
      .o_result(s_result), .o_i(s_i), .o_j(s_j), .o_done(s_done), .o_busy(s_busy)
   );

   typedef struct {
      logic          st, ab, hd, vl;
      logic [DW-1:0] dt;
      logic          rdy, sto, dn, bsy;
      logic [4:0]    ei, ej;
      logic [DW-1:0] res;
   } vec_t;

   vec_t tbl[11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic drive(input logic st, input logic ab, input logic hd, input logic vl,
                        input logic [DW-1:0] dt);
      start = st; abort = ab; hold = hd; valid = vl; data = dt;
   endtask

   task automatic check_model();
      chk("in_ready", 32'(in_ready), 32'(m_phase == 1 && !hold));
      chk("busy",     32'(busy),     32'(m_phase == 1 || m_phase == 2));
      chk("done",     32'(done),     32'(m_phase == 3));
      chk("store",    32'(store),    32'(m_store));
      chk("i",        32'(oi),       32'(m_i));
      chk("j",        32'(oj),       32'(m_j));
      chk("result",   32'(result),   32'(m_res));
      if (store) tb_stores++;
      if (done) tb_dones++;
   endtask

   // Advance the model by one clock using the currently driven inputs, then clock the DUT
   task automatic adv();
      bit acc;
      acc = (m_phase == 1) && !hold && valid;
      m_store = acc;
      if (acc) begin
         m_res = data;
         m_i = m_n / W;
         m_j = m_n % W;
      end
      if (abort) begin
         m_phase = 0;
         m_n = 0;
      end else if (m_phase == 0) begin
         if (start) begin
            m_phase = 1;
            m_n = 0;
         end
      end else if (m_phase == 1) begin
         if (acc) begin
            m_n++;
            if (m_n == N) m_phase = 2;
         end
      end else if (m_phase == 2) begin
         m_phase = 3;
      end else begin
         m_phase = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic st, input logic ab, input logic hd, input logic vl,
                       input logic [DW-1:0] dt);
      drive(st, ab, hd, vl, dt);
      #3;
      check_model();
      adv();
   endtask

   task automatic model_reset();
      m_phase = 0; m_n = 0; m_store = 1'b0; m_res = '0; m_i = 0; m_j = 0;
   endtask

   initial begin
      tbl[0]  = '{0, 0, 0, 1, 19'd3, 0, 0, 0, 0, 5'd0, 5'd0, 19'd0};
      tbl[1]  = '{1, 0, 0, 0, 19'd0, 0, 0, 0, 0, 5'd0, 5'd0, 19'd0};
      tbl[2]  = '{0, 0, 0, 1, 19'd5, 1, 0, 0, 1, 5'd0, 5'd0, 19'd0};
      tbl[3]  = '{0, 0, 0, 1, 19'd6, 1, 1, 0, 1, 5'd0, 5'd0, 19'd5};
      tbl[4]  = '{0, 0, 1, 1, 19'd7, 0, 1, 0, 1, 5'd0, 5'd1, 19'd6};
      tbl[5]  = '{1, 0, 0, 1, 19'd7, 1, 0, 0, 1, 5'd0, 5'd1, 19'd6};
      tbl[6]  = '{0, 0, 0, 0, 19'd0, 1, 1, 0, 1, 5'd0, 5'd2, 19'd7};
      tbl[7]  = '{0, 1, 0, 1, 19'd9, 1, 0, 0, 1, 5'd0, 5'd2, 19'd7};
      tbl[8]  = '{0, 0, 0, 1, 19'd4, 0, 1, 0, 0, 5'd0, 5'd3, 19'd9};
      tbl[9]  = '{1, 1, 0, 0, 19'd0, 0, 0, 0, 0, 5'd0, 5'd3, 19'd9};
      tbl[10] = '{0, 0, 0, 1, 19'd1, 0, 0, 0, 0, 5'd0, 5'd3, 19'd9};

      // Reset values while rst is held low
      #2;
      chk("rst_store", 32'(store), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ready", 32'(in_ready), 0);
      chk("rst_i", 32'(oi), 0);
      chk("rst_j", 32'(oj), 0);
      chk("rst_result", 32'(result), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Vector table: ignored inputs, hold, start in RUN, abort with in-flight store
      for (int k = 0; k < 11; k++) begin
         drive(tbl[k].st, tbl[k].ab, tbl[k].hd, tbl[k].vl, tbl[k].dt);
         #3;
         chk($sformatf("tbl%0d_ready", k), 32'(in_ready), 32'(tbl[k].rdy));
         chk($sformatf("tbl%0d_store", k), 32'(store), 32'(tbl[k].sto));
         chk($sformatf("tbl%0d_done", k), 32'(done), 32'(tbl[k].dn));
         chk($sformatf("tbl%0d_busy", k), 32'(busy), 32'(tbl[k].bsy));
         chk($sformatf("tbl%0d_i", k), 32'(oi), 32'(tbl[k].ei));
         chk($sformatf("tbl%0d_j", k), 32'(oj), 32'(tbl[k].ej));
         chk($sformatf("tbl%0d_result", k), 32'(result), 32'(tbl[k].res));
         check_model();
         adv();
      end

      // Full frame without stalls, data = element index
      tb_stores = 0; tb_dones = 0;
      step(1, 0, 0, 0, '0);
      for (int n = 0; n < N; n++) step(0, 0, 0, 1, DW'(n));
      for (int k = 0; k < 3; k++) step(0, 0, 0, 0, '0);
      chk("full_stores", 32'(tb_stores), 32'(N));
      chk("full_done", 32'(tb_dones), 1);

      // Bubbled input with a 5-cycle hold at element 30
      tb_stores = 0; tb_dones = 0;
      step(1, 0, 0, 0, '0);
      for (int c = 0; c < 4 * N && m_phase == 1; c++) begin
         if (m_n == 30 && c % 2 == 0) begin
            for (int h = 0; h < 5; h++) step(0, 0, 1, 1, DW'(30));
         end
         step(0, 0, 0, c % 2 == 0, DW'(m_n));
      end
      for (int k = 0; k < 3; k++) step(0, 0, 0, 0, '0);
      chk("bubble_stores", 32'(tb_stores), 32'(N));
      chk("bubble_done", 32'(tb_dones), 1);

      // Abort after 100 accepts, then restart from (0, 0)
      tb_stores = 0; tb_dones = 0;
      step(1, 0, 0, 0, '0);
      for (int n = 0; n < 100; n++) step(0, 0, 0, 1, DW'(n));
      step(0, 1, 0, 1, DW'(100));
      for (int k = 0; k < 4; k++) step(0, 0, 0, 1, '0);
      chk("abort_stores", 32'(tb_stores), 101);
      chk("abort_done", 32'(tb_dones), 0);
      step(1, 0, 0, 0, '0);
      step(0, 0, 0, 1, DW'(77));
      step(0, 0, 0, 0, '0);
      step(0, 1, 0, 0, '0);

      // Asynchronous reset at element 400
      step(0, 0, 0, 0, '0);
      step(1, 0, 0, 0, '0);
      for (int n = 0; n < 400; n++) step(0, 0, 0, 1, DW'(n));
      drive(0, 0, 0, 1, DW'(400));
      #2;
      rst = 1'b0;
      #1;
      chk("arst_store", 32'(store), 0);
      chk("arst_done", 32'(done), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_ready", 32'(in_ready), 0);
      chk("arst_i", 32'(oi), 0);
      chk("arst_result", 32'(result), 0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      tb_stores = 0; tb_dones = 0;
      for (int k = 0; k < 5; k++) step(0, 0, 0, 1, DW'(k));
      chk("arst_quiet", 32'(tb_stores + tb_dones), 0);

      // Single-element frame on the W=1, H=1 instance
      s_start = 1'b1;
      step(0, 0, 0, 0, '0);
      s_start = 1'b0; s_valid = 1'b1; s_data = DW'(42);
      #1;
      chk("one_ready", 32'(s_ready), 1);
      step(0, 0, 0, 0, '0);
      s_valid = 1'b0;
      chk("one_store", 32'(s_store), 1);
      chk("one_result", 32'(s_result), 42);
      chk("one_ij", 32'({s_i, s_j}), 0);
      chk("one_flush_busy", 32'(s_busy), 1);
      chk("one_flush_done", 32'(s_done), 0);
      step(0, 0, 0, 0, '0);
      chk("one_done", 32'(s_done), 1);
      chk("one_done_store", 32'(s_store), 0);
      chk("one_done_busy", 32'(s_busy), 0);
      step(0, 0, 0, 0, '0);
      chk("one_idle_done", 32'(s_done), 0);

      // Random traffic against the model
      for (int c = 0; c < 4000; c++) begin
         step($urandom_range(3) == 0, $urandom_range(399) == 0, $urandom_range(4) == 0,
              $urandom_range(3) != 0, DW'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/result_store_ctrl.md
Name: result_store_ctrl

Overview:
- Sequencer between the convolution output datapath and the result register file.
- Accepts one result per valid/ready handshake and assigns it raster-order (row i, column j) indices over an H x W output map.
- Drives the register file's store/result/i/j inputs and raises a one-cycle done pulse once the final element of a frame is committed.
- Supports downstream hold (back-pressure) and synchronous abort.

Parameters:
- W, 28, output map width (columns); 1..32
- H, 28, output map height (rows); 1..32
- DW, 19, result data width

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- start  input  1  begin a frame; honoured only in IDLE
- abort  input  1  synchronous abort; returns to IDLE with no done
- hold  input  1  downstream stall; deasserts in_ready
- in_valid  input  1  datapath result valid
- in_data  input  DW  datapath result
- in_ready  output  1  controller can accept in_data this cycle
- store  output  1  write strobe to the register file
- result  output  DW  data to the register file
- i  output  5  row index for the current store
- j  output  5  column index for the current store
- done  output  1  one-cycle pulse; frame complete
- busy  output  1  high in RUN and FLUSH

Behaviour:
- Reset values (async, rst=0): state IDLE; row/col counters 0; store=0, result=0, i=0, j=0, done=0, busy=0, in_ready=0.
- State IDLE:
  - in_ready=0.
  - start=1 moves to RUN and clears the counters (row=0, col=0).
- State RUN:
  - in_ready = !hold. Combinational from state and hold only; never from in_valid.
  - Accept = in_valid & in_ready.
  - On accept, in the next cycle (1-cycle latency, registered): store=1, result=in_data, i=row, j=col, where row/col are the values before the increment.
  - Increment on accept: if col==W-1 then col=0 and row=row+1; else col=col+1.
  - Accepting element (H-1, W-1) moves the state to FLUSH.
- State FLUSH:
  - in_ready=0.
  - The final store pulse is issued this cycle; move to DONE.
- State DONE:
  - done=1 for exactly this cycle; busy=0; move to IDLE.
- store is 0 in every cycle that does not follow an accept.
- i, j and result hold their last values when store=0.
- Back-to-back accepts produce back-to-back store pulses. Throughput is 1 element per cycle.
- Holding data while stalled:
  - When hold=1, no accept occurs and the counters hold.
  - in_valid/in_data held by the source are accepted when hold drops.
- in_valid outside RUN is ignored: no store, no counter change.
- start outside IDLE is ignored.
- abort=1 in any state:
  - Next state IDLE; counters cleared; done not asserted.
  - A store already registered from an accept in the same cycle is still issued the next cycle.
  - abort has priority over start and over the accept-driven transition to FLUSH.
  - The counters do not advance on the abort cycle.
- Simultaneous start and abort in IDLE: remain in IDLE.
- Reset mid-frame: all state cleared immediately; no store or done is issued afterwards until a new start.
- Corner case W=1, H=1: a single accept goes RUN -> FLUSH -> DONE. done fires 2 cycles after the accept, 1 cycle after the store.
- Total stores per completed frame = H*W exactly (784 at defaults).

Test Plan:
- Full frame, no stalls: start, then in_valid=1 for 784 cycles with in_data = element index.
  - 784 consecutive store pulses.
  - Store n carries i=n/28, j=n%28, result=n.
  - Last store at i=27, j=27; done one cycle later; busy falls with done.
- Hold stall: during a frame, assert hold for 5 cycles at element 30 (i=1, j=2).
  - in_ready=0 and no store during the stall.
  - Element 30 is stored with i=1, j=2 after hold drops; no skipped or duplicated index.
- Bubbled input: in_valid toggles every other cycle.
  - Stores appear only on cycles following an accept; indices remain contiguous.
  - done appears only after the 784th accept.
- Abort mid-frame: abort after 100 accepts.
  - No further stores beyond the in-flight one; no done; state returns to IDLE.
  - A new start produces the first store at i=0, j=0.
- Ignored inputs: in_valid=1 and a second start while in IDLE/DONE; start during RUN.
  - No stores; counters unchanged.
  - Frame proceeds without a restart.
- Async reset at element 400: drop rst mid-cycle.
  - store, done, busy and in_ready go to 0 immediately.
  - After release, no activity until start.
